// File: rtl/qq_op_ctrl_if.sv
// Client request/response bus and queue-engine strobe bus used by the
// QuickQ request sequencer.
interface qq_req_if #(parameter int DW = 32);
  logic          req_valid;
  logic          req_op;
  logic [DW-1:0] req_data;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_ready;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

interface qq_eng_if #(parameter int DW = 32);
  logic          enq;
  logic          deq;
  logic [DW-1:0] eng_data;
  logic          eng_done;
  logic [DW-1:0] eng_rdata;
  logic [31:0]   last_addr;
  logic [31:0]   new_last;

  modport master (
    output enq, deq, eng_data, last_addr,
    input  eng_done, eng_rdata, new_last
  );
  modport slave (
    input  enq, deq, eng_data, last_addr,
    output eng_done, eng_rdata, new_last
  );
endinterface

// File: rtl/qq_op_ctrl.sv
// QuickQ request sequencer: screens client enq/deq requests, holds the engine
// strobe until done, adopts the counter's new last pointer and responds.
//
// state | meaning
// IDLE  | ready for a client request
// ISSUE | enq/deq strobe held, waiting for eng_done or timeout
// UPD   | new_last valid; adopt it and check against expected pointer
// RESP  | response presented until rsp_ready
module qq_op_ctrl #(
  parameter int DEPTH   = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  qq_req_if.slave    req,
  qq_eng_if.master   eng,
  output logic       full,
  output logic       empty,
  output logic       sync_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, UPD, RESP} state_t;

  state_t        state_q, state_d;
  logic          op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          enq_q, enq_d;
  logic          deq_q, deq_d;
  logic [31:0]   last_q, last_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          sync_q, sync_d;
  logic [31:0]   exp_last;
  logic          mismatch;

  assign full          = (last_q == 32'(DEPTH));
  assign empty         = (last_q == 32'd0);
  assign req.req_ready = (state_q == IDLE) && rst;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_data  = rsp_data_q;
  assign req.rsp_err   = rsp_err_q;
  assign eng.enq       = enq_q;
  assign eng.deq       = deq_q;
  assign eng.eng_data  = data_q;
  assign eng.last_addr = last_q;
  assign sync_err      = sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      data_q      <= '0;
      rdata_q     <= '0;
      tmr_q       <= '0;
      enq_q       <= 1'b0;
      deq_q       <= 1'b0;
      last_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      tmr_q       <= tmr_d;
      enq_q       <= enq_d;
      deq_q       <= deq_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      sync_q      <= sync_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    tmr_d       = tmr_q;
    enq_d       = enq_q;
    deq_d       = deq_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    sync_d      = sync_q;
    exp_last    = op_q ? (last_q + 32'd1) : (last_q - 32'd1);
    mismatch    = (eng.new_last != exp_last);

    unique case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          op_d    = req.req_op;
          data_d  = req.req_data;
          rdata_d = '0;
          if ((req.req_op && full) || (!req.req_op && empty)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = ISSUE;
            enq_d   = req.req_op;
            deq_d   = !req.req_op;
            tmr_d   = TMR_LOAD;
          end
        end
      end
      ISSUE: begin
        if (eng.eng_done) begin
          enq_d   = 1'b0;
          deq_d   = 1'b0;
          if (!op_q) rdata_d = eng.eng_rdata;
          state_d = UPD;
        end else if (tmr_q == '0) begin
          // Engine never answered: abort without touching the pointer.
          enq_d       = 1'b0;
          deq_d       = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      UPD: begin
        last_d      = eng.new_last;
        if (mismatch) sync_d = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_err_d   = mismatch;
        rsp_data_d  = (op_q || mismatch) ? '0 : rdata_q;
        state_d     = RESP;
      end
      RESP: begin
        if (req.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_qq_op_ctrl.sv
// Directed bench for qq_op_ctrl with a small engine/last-pointer counter model.
module tb_qq_op_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qq_req_if #(.DW(32)) rif();
  qq_eng_if #(.DW(32)) eif();
  logic full, empty, sync_err;

  qq_op_ctrl #(.DEPTH(16), .DW(32), .TIMEOUT(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (rif.slave),
    .eng      (eif.master),
    .full     (full),
    .empty    (empty),
    .sync_err (sync_err)
  );

  bit          auto_done = 1'b1;
  logic [31:0] enq_step  = 32'd1;
  logic [31:0] rdata_val = 32'd0;
  int          strobe_total = 0;
  logic [31:0] seen_key = 32'd0;

  assign eif.eng_rdata = rdata_val;

  // Engine answers one cycle after the strobe; counter registers new_last on op&&done.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eif.eng_done <= 1'b0;
      eif.new_last <= 32'd0;
    end else begin
      eif.eng_done <= auto_done && (eif.enq || eif.deq) && !eif.eng_done;
      if ((eif.enq || eif.deq) && eif.eng_done)
        eif.new_last <= eif.enq ? (eif.last_addr + enq_step) : (eif.last_addr - 32'd1);
    end
  end

  always @(posedge clk) begin
    if (eif.enq || eif.deq) strobe_total <= strobe_total + 1;
    if (eif.enq) seen_key <= eif.eng_data;
  end

  int n_pass = 0;
  int n_chk  = 0;
  logic [31:0] got_data;
  logic        got_err;
  int          lat;
  int          strobes;
  logic [31:0] keys [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic op, input logic [31:0] d);
    int s0;
    rif.req_op    = op;
    rif.req_data  = d;
    rif.req_valid = 1'b1;
    s0 = strobe_total;
    tick();
    rif.req_valid = 1'b0;
    lat = 1;
    while (!rif.rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    got_data = rif.rsp_data;
    got_err  = rif.rsp_err;
    strobes  = strobe_total - s0;
  endtask

  task automatic ack();
    rif.rsp_ready = 1'b1;
    tick();
    rif.rsp_ready = 1'b0;
  endtask

  initial begin
    rif.req_valid = 1'b0;
    rif.req_op    = 1'b0;
    rif.req_data  = 32'd0;
    rif.rsp_ready = 1'b0;
    keys[0] = 32'd5; keys[1] = 32'd9; keys[2] = 32'd2;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_req_ready", 32'(rif.req_ready), 0);
    chk("rst_enq", 32'(eif.enq), 0);
    chk("rst_rsp_valid", 32'(rif.rsp_valid), 0);
    chk("rst_last", eif.last_addr, 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_empty", 32'(empty), 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_req_ready", 32'(rif.req_ready), 1);

    // dequeue from empty is rejected without a strobe
    send(1'b0, 32'd0);
    chk("deq_empty_lat", lat, 1);
    chk("deq_empty_err", 32'(got_err), 1);
    chk("deq_empty_data", got_data, 0);
    chk("deq_empty_strobes", strobes, 0);
    chk("deq_empty_last", eif.last_addr, 0);
    ack();

    for (int i = 0; i < 3; i++) begin
      send(1'b1, keys[i]);
      chk("enq_lat", lat, 4);
      chk("enq_err", 32'(got_err), 0);
      chk("enq_strobes", strobes, 2);
      chk("enq_key", seen_key, keys[i]);
      ack();
    end
    chk("enq3_last", eif.last_addr, 3);
    chk("enq3_empty", 32'(empty), 0);

    for (int i = 3; i < 16; i++) begin
      send(1'b1, 32'(i + 100));
      ack();
    end
    chk("fill_last", eif.last_addr, 16);
    chk("fill_full", 32'(full), 1);

    send(1'b1, 32'd77);
    chk("enq_full_lat", lat, 1);
    chk("enq_full_err", 32'(got_err), 1);
    chk("enq_full_strobes", strobes, 0);
    chk("enq_full_last", eif.last_addr, 16);
    ack();

    rdata_val = 32'h2;
    send(1'b0, 32'd0);
    chk("deq_full_data", got_data, 32'h2);
    chk("deq_full_err", 32'(got_err), 0);
    chk("deq_full_last", eif.last_addr, 15);
    chk("deq_full_full", 32'(full), 0);
    ack();

    // engine never answers
    auto_done = 1'b0;
    send(1'b1, 32'h55);
    chk("tmo_lat", lat, 65);
    chk("tmo_strobes", strobes, 64);
    chk("tmo_enq", 32'(eif.enq), 0);
    chk("tmo_err", 32'(got_err), 1);
    chk("tmo_data", got_data, 0);
    chk("tmo_last", eif.last_addr, 15);
    ack();
    auto_done = 1'b1;

    rdata_val = 32'h7;
    send(1'b0, 32'd0);
    chk("post_tmo_lat", lat, 4);
    chk("post_tmo_data", got_data, 32'h7);
    chk("post_tmo_err", 32'(got_err), 0);
    chk("post_tmo_last", eif.last_addr, 14);
    ack();

    // counter returns last+2 on an enqueue
    enq_step = 32'd2;
    send(1'b1, 32'h66);
    chk("sync_err_flag", 32'(sync_err), 1);
    chk("sync_rsp_err", 32'(got_err), 1);
    chk("sync_data", got_data, 0);
    chk("sync_last", eif.last_addr, 16);
    ack();
    enq_step = 32'd1;

    rdata_val = 32'h3;
    send(1'b0, 32'd0);
    chk("sticky_sync", 32'(sync_err), 1);
    chk("sticky_err", 32'(got_err), 0);
    chk("sticky_data", got_data, 32'h3);
    chk("sticky_last", eif.last_addr, 15);
    ack();

    // response held while rsp_ready stays low
    rdata_val = 32'h33;
    send(1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(rif.rsp_valid), 1);
      chk("hold_data", rif.rsp_data, 32'h33);
      chk("hold_err", 32'(rif.rsp_err), 0);
    end
    ack();
    chk("hold_last", eif.last_addr, 14);

    // reset asserted while the strobe is up
    rif.req_op    = 1'b1;
    rif.req_data  = 32'h44;
    rif.req_valid = 1'b1;
    tick();
    rif.req_valid = 1'b0;
    chk("mid_issue_enq", 32'(eif.enq), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_enq", 32'(eif.enq), 0);
    chk("mid_rst_rsp_valid", 32'(rif.rsp_valid), 0);
    chk("mid_rst_last", eif.last_addr, 0);
    chk("mid_rst_sync", 32'(sync_err), 0);
    chk("mid_rst_req_ready", 32'(rif.req_ready), 0);
    @(negedge clk);
    rst = 1'b1;

    send(1'b1, 32'h11);
    chk("after_rst_lat", lat, 4);
    chk("after_rst_err", 32'(got_err), 0);
    chk("after_rst_last", eif.last_addr, 1);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qq_op_ctrl.md
Name: qq_op_ctrl

Overview:
Request-side sequencer for the QuickQ priority queue: the initiator that drives the enq/deq/done/last_addr interface whose responder is the last-pointer counter. Accepts one enqueue or dequeue request at a time from a client over valid/ready, screens it against full/empty, and holds the queue engine's enq/deq strobe until done. It then adopts the counter's new_last as the current last pointer and returns a response with dequeued data or an error.

Parameters:
DEPTH, 16, queue capacity in entries; last pointer ranges 0..DEPTH.
DW, 32, key/data width.
TIMEOUT, 64, max cycles in ISSUE waiting for eng_done before abort (>=2).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  client request valid.
req_op  in  1  1=enqueue, 0=dequeue.
req_data  in  DW  key to enqueue; ignored for dequeue.
req_ready  out  1  controller can accept a request.
rsp_valid  out  1  response valid.
rsp_data  out  DW  dequeued key; 0 for enqueue or error.
rsp_err  out  1  request rejected, timed out, or pointer mismatch.
rsp_ready  in  1  client accepts response.
enq  out  1  enqueue strobe to engine and counter, held until done.
deq  out  1  dequeue strobe to engine and counter, held until done.
eng_data  out  DW  key presented with enq.
eng_done  in  1  engine completion, sampled while enq/deq high.
eng_rdata  in  DW  dequeued key, valid in the eng_done cycle.
last_addr  out  32  current last pointer, fed to the counter.
new_last  in  32  counter's registered updated pointer.
full  out  1  last_addr == DEPTH.
empty  out  1  last_addr == 0.
sync_err  out  1  sticky: new_last != expected value.

Behaviour:
- Reset (rst low, async): state IDLE; last_addr=0; enq=deq=0; rsp_valid=0, rsp_data=0, rsp_err=0; sync_err=0; timeout counter=0; req_ready=0 while rst is low.
- All outputs are registered except req_ready, full, and empty, which decode from state and last_addr.
- States: IDLE, ISSUE, UPD, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op and data.
  - If (enq && full) or (deq && empty): go to RESP with rsp_err=1 and rsp_data=0. No strobe is issued and last_addr is unchanged.
  - Otherwise go to ISSUE.
- ISSUE: assert enq or deq (exactly one) with eng_data=latched key. Clear the timeout counter on entry.
  - Strobe stays high up to and including the cycle eng_done is sampled high. The counter requires op and done together.
  - On eng_done: capture eng_rdata if deq, drop the strobe next cycle, go to UPD.
  - If TIMEOUT cycles elapse without eng_done: drop the strobe, go to RESP with rsp_err=1. last_addr is unchanged.
- UPD (one cycle): new_last is now valid.
  - Set last_addr <= new_last.
  - Expected value is old last_addr+1 for enq, -1 for deq. On mismatch, set sync_err=1 (sticky until reset) and rsp_err=1. new_last is still adopted.
  - Go to RESP.
- RESP: rsp_valid=1 with rsp_data and rsp_err stable until rsp_ready. On handshake, clear rsp_valid, rsp_err, and rsp_data, then go to IDLE.
  - req_ready=0 in RESP, so there is no same-cycle overlap with a new request.
- Latency: accept at cycle 0, ISSUE from cycle 1. If done arrives in cycle 1: UPD in cycle 2, rsp_valid in cycle 3. Reject path: rsp_valid in cycle 1.
- Arithmetic: last_addr is 32-bit unsigned. Compare against DEPTH zero-extended. The expected-value compare wraps mod 2^32.
- eng_done outside ISSUE is ignored.
- Reset mid-operation: strobes drop immediately, any pending response is lost, last_addr returns to 0.

Test Plan:
- Reset, then 3 enqueues (keys 5,9,2) with eng_done one cycle after the strobe and the model returning new_last=last_addr+1 -> last_addr=3, rsp_err=0, empty=0. The first response's rsp_valid appears 4 cycles after accept.
- Dequeue from empty after reset -> no enq/deq pulse, rsp_valid in the cycle after accept, rsp_err=1, rsp_data=0, last_addr=0.
- Fill to DEPTH=16, then enqueue -> full=1, rejected with rsp_err=1, last_addr stays 16. A following dequeue with eng_rdata=0x2 gives rsp_data=0x2 and last_addr=15.
- Hold eng_done low for TIMEOUT=64 cycles -> strobe deasserts after the 64th cycle, rsp_err=1, last_addr unchanged. The next request proceeds normally.
- Model returns new_last=last_addr+2 on an enqueue -> sync_err=1 (stays set), rsp_err=1, last_addr adopts the returned value.
- Hold rsp_ready low for 5 cycles, then assert rst low mid-ISSUE on the next request -> response stays stable for the 5 cycles. After reset, enq=0, rsp_valid=0, and last_addr=0 immediately, without waiting for a clock edge.
